mat_mult_seq_ctrl: RTL and testbench

- Sequencing controller and shared-MAC scheduler for the 3x3 unsigned 8-bit matrix-multiply accelerator.
- Software loads operand matrices A and B element by element, then pulses start. The block computes C = A x B through a single time-shared multiply-accumulate unit, one MAC per cycle.
- Results are held in a C buffer and read back through a registered read port.
- Sits between the core-side peripheral register interface and the accelerator storage.

---
 rtl/mat_mult_seq_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_mat_mult_seq_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_mult_seq_ctrl.sv
// mat_mult_seq_ctrl: sequencing controller for a 3x3 unsigned matrix multiply.
// Operands A and B are loaded element by element. A start request runs
// C = A x B on one shared MAC, one multiply-accumulate per cycle (27 cycles).
// Results are read back through a registered read port.
// Optional build macro MM_SEQ_IRQ_EN adds a sticky interrupt output irq_o.
// The interrupt sets on done/err. A B-side write to address 15 in IDLE clears it.
module mat_mult_seq_ctrl #(
  parameter int DAT_W = 8,
  parameter int ACC_W = 18,
  parameter int DIM   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic             wr_sel_i,
  input  logic [3:0]       wr_addr_i,
  input  logic [DAT_W-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [3:0]       rd_addr_i,
  output logic [ACC_W-1:0] rd_data_o,
  output logic             rd_valid_o,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
`ifdef MM_SEQ_IRQ_EN
  ,
  output logic             irq_o
`endif
);

  // The counters below are 2 bits wide, so DIM is fixed at 3.
  localparam int         NEL       = DIM * DIM;
  localparam logic [3:0] LAST_ADDR = 4'(NEL - 1);
  localparam logic [1:0] LAST_IDX  = 2'(DIM - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // The product is zero-extended to ACC_W.
  // Three terms of at most 255*255 each cannot overflow ACC_W.
  function automatic logic [ACC_W-1:0] mac_term(input logic [DAT_W-1:0] a,
                                                input logic [DAT_W-1:0] b);
    logic [2*DAT_W-1:0] p;
    p = a * b;
    return {{(ACC_W - 2 * DAT_W){1'b0}}, p};
  endfunction

  state_e           state_q, state_d;
  logic [1:0]       row_q, row_d, col_q, col_d, k_q, k_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
  logic [3:0]       a_idx, b_idx, c_idx;
  logic             c_we;

  logic [DAT_W-1:0] a_q [NEL];
  logic [DAT_W-1:0] b_q [NEL];
  logic [ACC_W-1:0] c_q [NEL];

  logic             idle;
  logic             irq_clr;
  logic             wr_ok;
  logic             err_d, err_q;
  logic [ACC_W-1:0] rd_word, rd_data_q;
  logic             rd_valid_q;

  assign idle = (state_q == S_IDLE);

`ifdef MM_SEQ_IRQ_EN
  assign irq_clr = wr_en_i & wr_sel_i & idle & (wr_addr_i == 4'hF);
`else
  assign irq_clr = 1'b0;
`endif

  // Operand write acceptance and protocol-error detection.
  // Several error causes in one cycle still give a single pulse.
  always_comb begin
    wr_ok = wr_en_i & idle & (wr_addr_i <= LAST_ADDR);
    err_d = 1'b0;
    if (wr_en_i && (wr_addr_i > LAST_ADDR) && !irq_clr) err_d = 1'b1;
    if (wr_en_i && !idle)                               err_d = 1'b1;
    if (start_i && !idle)                               err_d = 1'b1;
    if (rd_en_i && (rd_addr_i > LAST_ADDR))             err_d = 1'b1;
  end

  // MAC operand addressing: A[3r+k] * B[3k+c] feeds C[3r+c].
  always_comb begin
    a_idx   = 4'(row_q) * 4'(DIM) + 4'(k_q);
    b_idx   = 4'(k_q) * 4'(DIM) + 4'(col_q);
    c_idx   = 4'(row_q) * 4'(DIM) + 4'(col_q);
    acc_sum = acc_q + mac_term(a_q[a_idx], b_q[b_idx]);
  end

  // Next-state logic and MAC sequencing: row-major over C, inner loop over k.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    k_d     = k_q;
    acc_d   = acc_q;
    c_we    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RUN;
          row_d   = '0;
          col_d   = '0;
          k_d     = '0;
          acc_d   = '0;
        end
      end
      S_RUN: begin
        if (k_q == LAST_IDX) begin
          c_we  = 1'b1;
          acc_d = '0;
          k_d   = '0;
          if (col_q == LAST_IDX) begin
            col_d = '0;
            if (row_q == LAST_IDX) begin
              row_d   = '0;
              state_d = S_DONE;
            end else begin
              row_d = row_q + 2'd1;
            end
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          acc_d = acc_sum;
          k_d   = k_q + 2'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      k_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
    end
  end

  // Operand and result storage.
  // A write in the same cycle as start lands before the first MAC reads it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NEL; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
        c_q[i] <= '0;
      end
    end else begin
      if (wr_ok) begin
        if (wr_sel_i) b_q[wr_addr_i] <= wr_data_i;
        else          a_q[wr_addr_i] <= wr_data_i;
      end
      if (c_we) c_q[c_idx] <= acc_sum;
    end
  end

  // Read mux: out-of-range addresses return zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NEL; i++) begin
      if (rd_addr_i == 4'(i)) rd_word = c_q[i];
    end
  end

  // Registered read port. The data holds its last value when no read is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en_i;
      if (rd_en_i) rd_data_q <= rd_word;
    end
  end

  // One-cycle error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

`ifdef MM_SEQ_IRQ_EN
  logic irq_q;

  // Sticky interrupt. A set in the same cycle as a clear takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q <= 1'b0;
    end else if (done_o || err_q) begin
      irq_q <= 1'b1;
    end else if (irq_clr) begin
      irq_q <= 1'b0;
    end
  end

  assign irq_o = irq_q;
`endif

  assign busy_o     = (state_q == S_RUN);
  assign done_o     = (state_q == S_DONE);
  assign err_o      = err_q;
  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: tb/tb_mat_mult_seq_ctrl.sv
// Self-checking bench for mat_mult_seq_ctrl.
// A reference model computes C = A x B with plain integer arithmetic.
module tb_mat_mult_seq_ctrl;
  localparam int DAT_W = 8;
  localparam int ACC_W = 18;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wr_en_i = 1'b0;
  logic             wr_sel_i = 1'b0;
  logic [3:0]       wr_addr_i = '0;
  logic [DAT_W-1:0] wr_data_i = '0;
  logic             rd_en_i = 1'b0;
  logic [3:0]       rd_addr_i = '0;
  logic [ACC_W-1:0] rd_data_o;
  logic             rd_valid_o;
  logic             start_i = 1'b0;
  logic             busy_o, done_o, err_o;
`ifdef MM_SEQ_IRQ_EN
  logic             irq_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int ma[9];
  int mb[9];
  int mc[9];

  always #5 clk = ~clk;

  mat_mult_seq_ctrl #(.DAT_W(DAT_W), .ACC_W(ACC_W), .DIM(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en_i(wr_en_i), .wr_sel_i(wr_sel_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
    .start_i(start_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
`ifdef MM_SEQ_IRQ_EN
    , .irq_o(irq_o)
`endif
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic compute_model();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        mc[3*r+c] = 0;
        for (int k = 0; k < 3; k++) mc[3*r+c] += ma[3*r+k] * mb[3*k+c];
      end
  endtask

  task automatic write_op(input logic sel, input logic [3:0] addr, input logic [7:0] data);
    wr_en_i = 1'b1; wr_sel_i = sel; wr_addr_i = addr; wr_data_i = data;
    cyc();
    wr_en_i = 1'b0;
  endtask

  task automatic load_model();
    for (int i = 0; i < 9; i++) write_op(1'b0, 4'(i), 8'(ma[i]));
    for (int i = 0; i < 9; i++) write_op(1'b1, 4'(i), 8'(mb[i]));
    compute_model();
  endtask

  task automatic read_c(input logic [3:0] addr, output logic [17:0] d, output logic v, output logic e);
    rd_en_i = 1'b1; rd_addr_i = addr;
    cyc();
    rd_en_i = 1'b0;
    d = rd_data_o; v = rd_valid_o; e = err_o;
  endtask

  // Runs one computation for 32 cycles after the start edge. A start and/or
  // an A[0] write can be injected in given RUN cycles (0 = none). Each
  // injection must show up as an err_o pulse in the following cycle.
  task automatic run_compute(input int inj_start, input int inj_wr,
                             output int busy_cnt, output int done_at,
                             output int done_cnt, output int err_bad);
    logic exp_err;
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    busy_cnt = 0; done_at = 0; done_cnt = 0; err_bad = 0;
    for (int t = 1; t <= 32; t++) begin
      exp_err = (inj_start != 0 && t == inj_start + 1) || (inj_wr != 0 && t == inj_wr + 1);
      if (err_o !== exp_err) err_bad++;
      if (busy_o === 1'b1) busy_cnt++;
      if (done_o === 1'b1) begin
        done_cnt++;
        if (done_at == 0) done_at = t;
      end
      start_i   = (t == inj_start);
      wr_en_i   = (t == inj_wr);
      wr_sel_i  = 1'b0;
      wr_addr_i = 4'd0;
      wr_data_i = 8'(~ma[0]);
      cyc();
    end
    start_i = 1'b0;
    wr_en_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [17:0] d; logic v, e;
    rst_n = 1'b0;
    repeat (3) cyc();
    n_tests++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0 || rd_valid_o !== 1'b0 || rd_data_o !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b err=%b vld=%b data=%0d, expected all 0",
               busy_o, done_o, err_o, rd_valid_o, rd_data_o);
    end
`ifdef MM_SEQ_IRQ_EN
    n_tests++;
    if (irq_o !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq_o); end
`endif
    rst_n = 1'b1;
    cyc();
    read_c(4'd4, d, v, e);
    n_tests++;
    if (d !== 18'd0 || v !== 1'b1 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_read: got data=%0d vld=%b err=%b expected 0/1/0", d, v, e);
    end
  endtask

  task automatic test_identity();
    int bc, da, dc, eb; logic [17:0] d; logic v, e;
    for (int i = 0; i < 9; i++) begin
      ma[i] = (i % 4 == 0) ? 1 : 0;
      mb[i] = i + 1;
    end
    load_model();
    run_compute(0, 0, bc, da, dc, eb);
    n_tests++;
    if (bc !== 27) begin n_fail++; $display("FAIL ident_busy_cycles: got %0d expected 27", bc); end
    n_tests++;
    if (da !== 28 || dc !== 1) begin
      n_fail++; $display("FAIL ident_done: got cycle %0d count %0d expected cycle 28 count 1", da, dc);
    end
    n_tests++;
    if (eb !== 0) begin n_fail++; $display("FAIL ident_err: got %0d bad err cycles expected 0", eb); end
    for (int i = 0; i < 9; i++) begin
      read_c(4'(i), d, v, e);
      n_tests++;
      if (d !== 18'(i + 1) || v !== 1'b1) begin
        n_fail++; $display("FAIL ident_c%0d: got %0d vld=%b expected %0d vld=1", i, d, v, i + 1);
      end
    end
  endtask

  task automatic test_max();
    int bc, da, dc, eb; logic [17:0] d; logic v, e;
    for (int i = 0; i < 9; i++) begin ma[i] = 255; mb[i] = 255; end
    load_model();
    run_compute(0, 0, bc, da, dc, eb);
    for (int i = 0; i < 9; i++) begin
      read_c(4'(i), d, v, e);
      n_tests++;
      if (d !== 18'h2FA03 || v !== 1'b1) begin
        n_fail++; $display("FAIL max_c%0d: got %0d expected 195075", i, d);
      end
    end
  endtask

  task automatic test_pattern();
    int bc, da, dc, eb; logic [17:0] d; logic v, e;
    int exp_tab[9] = '{30, 24, 18, 84, 69, 54, 138, 114, 90};
    for (int i = 0; i < 9; i++) begin ma[i] = i + 1; mb[i] = 9 - i; end
    load_model();
    run_compute(0, 0, bc, da, dc, eb);
    for (int i = 0; i < 9; i++) begin
      read_c(4'(i), d, v, e);
      n_tests++;
      if (d !== 18'(exp_tab[i])) begin
        n_fail++; $display("FAIL pattern_c%0d: got %0d expected %0d", i, d, exp_tab[i]);
      end
    end
  endtask

  task automatic test_random();
    int bc, da, dc, eb; logic [17:0] d; logic v, e;
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 9; i++) begin
        ma[i] = int'($urandom_range(0, 255));
        mb[i] = int'($urandom_range(0, 255));
      end
      load_model();
      run_compute(0, 0, bc, da, dc, eb);
      n_tests++;
      if (da !== 28 || eb !== 0) begin
        n_fail++; $display("FAIL random%0d_timing: done at %0d err bad %0d expected 28/0", it, da, eb);
      end
      for (int i = 0; i < 9; i++) begin
        read_c(4'(i), d, v, e);
        n_tests++;
        if (d !== 18'(mc[i]) || v !== 1'b1) begin
          n_fail++; $display("FAIL random%0d_c%0d: got %0d expected %0d", it, i, d, mc[i]);
        end
      end
    end
  endtask

  task automatic test_run_errors();
    int bc, da, dc, eb; logic [17:0] d; logic v, e;
    for (int i = 0; i < 9; i++) begin
      ma[i] = int'($urandom_range(1, 255));
      mb[i] = int'($urandom_range(0, 255));
    end
    load_model();
    run_compute(5, 6, bc, da, dc, eb);
    n_tests++;
    if (eb !== 0) begin n_fail++; $display("FAIL runerr_err_pulses: got %0d bad err cycles expected 0", eb); end
    n_tests++;
    if (dc !== 1 || da !== 28) begin
      n_fail++; $display("FAIL runerr_done: got count %0d at %0d expected 1 at 28", dc, da);
    end
    for (int i = 0; i < 9; i++) begin
      read_c(4'(i), d, v, e);
      n_tests++;
      if (d !== 18'(mc[i])) begin
        n_fail++; $display("FAIL runerr_c%0d: got %0d expected %0d", i, d, mc[i]);
      end
    end
    // The ignored write must not have reached A[0], so a rerun gives the same C.
    run_compute(0, 0, bc, da, dc, eb);
    read_c(4'd0, d, v, e);
    n_tests++;
    if (d !== 18'(mc[0])) begin n_fail++; $display("FAIL runerr_a0_kept: got %0d expected %0d", d, mc[0]); end
  endtask

  task automatic test_addr_errors();
    int bc, da, dc, eb; logic [17:0] d; logic v, e;
    write_op(1'b0, 4'd9, 8'hAA);
    n_tests++;
    if (err_o !== 1'b1) begin n_fail++; $display("FAIL addr_wr9_err: got %b expected 1", err_o); end
    cyc();
    n_tests++;
    if (err_o !== 1'b0) begin n_fail++; $display("FAIL addr_err_single: got %b expected 0", err_o); end
`ifndef MM_SEQ_IRQ_EN
    write_op(1'b1, 4'd15, 8'h55);
    n_tests++;
    if (err_o !== 1'b1) begin n_fail++; $display("FAIL addr_wr15_err: got %b expected 1", err_o); end
`endif
    read_c(4'd12, d, v, e);
    n_tests++;
    if (d !== 18'd0 || v !== 1'b1 || e !== 1'b1) begin
      n_fail++; $display("FAIL addr_rd12: got data=%0d vld=%b err=%b expected 0/1/1", d, v, e);
    end
    run_compute(0, 0, bc, da, dc, eb);
    for (int i = 0; i < 9; i++) begin
      read_c(4'(i), d, v, e);
      n_tests++;
      if (d !== 18'(mc[i])) begin
        n_fail++; $display("FAIL addr_unchanged_c%0d: got %0d expected %0d", i, d, mc[i]);
      end
    end
  endtask

  task automatic test_reset_in_run();
    int dc; logic [17:0] d; logic v, e;
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    repeat (9) cyc();
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      n_fail++; $display("FAIL rstrun_busy: got busy=%b done=%b expected 0/0", busy_o, done_o);
    end
    cyc();
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin ma[i] = 0; mb[i] = 0; mc[i] = 0; end
    dc = 0;
    for (int t = 0; t < 35; t++) begin
      if (done_o === 1'b1 || busy_o === 1'b1) dc++;
      cyc();
    end
    n_tests++;
    if (dc !== 0) begin n_fail++; $display("FAIL rstrun_no_done: got %0d active cycles expected 0", dc); end
    for (int i = 0; i < 9; i++) begin
      read_c(4'(i), d, v, e);
      n_tests++;
      if (d !== 18'd0 || v !== 1'b1) begin
        n_fail++; $display("FAIL rstrun_c%0d: got %0d expected 0", i, d);
      end
    end
  endtask

`ifdef MM_SEQ_IRQ_EN
  task automatic test_irq();
    int bc, da, dc, eb; logic [17:0] d; logic v, e;
    for (int i = 0; i < 9; i++) begin ma[i] = int'($urandom_range(0, 255)); mb[i] = i + 3; end
    load_model();
    n_tests++;
    if (irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_idle: got %b expected 0", irq_o); end
    run_compute(0, 0, bc, da, dc, eb);
    n_tests++;
    if (irq_o !== 1'b1) begin n_fail++; $display("FAIL irq_set: got %b expected 1", irq_o); end
    write_op(1'b1, 4'd15, 8'hFF);
    n_tests++;
    if (irq_o !== 1'b0 || err_o !== 1'b0) begin
      n_fail++; $display("FAIL irq_clear: got irq=%b err=%b expected 0/0", irq_o, err_o);
    end
    run_compute(0, 0, bc, da, dc, eb);
    for (int i = 0; i < 9; i++) begin
      read_c(4'(i), d, v, e);
      n_tests++;
      if (d !== 18'(mc[i])) begin
        n_fail++; $display("FAIL irq_b_kept_c%0d: got %0d expected %0d", i, d, mc[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_identity();
    test_max();
    test_pattern();
    test_random();
    test_run_errors();
    test_addr_errors();
    test_reset_in_run();
`ifdef MM_SEQ_IRQ_EN
    test_irq();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
